// File: rtl/sap_pc_ir_datapath.sv
// SAP-1 program counter, memory address register and instruction register.
// Drives the shared bus from PC or the IR operand nibble and returns the opcode to control.
module sap_pc_ir_datapath #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              pc_inc,
  input  logic              pc_en,
  input  logic              pc_load,
  input  logic              mar_load_n,
  input  logic              ir_load_n,
  input  logic              ir_en_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] mar_addr,
  output logic [ADDR_W-1:0] pc_value,
  output logic              pc_wrapped,
  output logic              bus_conflict
);

  localparam int unsigned OP_W = 4;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              wrapped_q, wrapped_d;
  logic              conflict_q, conflict_d;

  // Next-state: load beats increment; halt freezes every register including sticky flags.
  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    wrapped_d  = wrapped_q;
    conflict_d = conflict_q;
    if (!halt) begin
      if (pc_load) begin
        pc_d = bus_in[ADDR_W-1:0];
      end else if (pc_inc) begin
        pc_d = pc_q + ADDR_W'(1);
        if (pc_q == {ADDR_W{1'b1}}) wrapped_d = 1'b1;
      end
      if (!mar_load_n) mar_d = bus_in[ADDR_W-1:0];
      if (!ir_load_n)  ir_d  = bus_in;
      if (pc_en && !ir_en_n) conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      wrapped_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      wrapped_q  <= wrapped_d;
      conflict_q <= conflict_d;
    end
  end

  // Bus drive: exactly one source drives; two requesters release the bus entirely.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    if (!halt) begin
      if (pc_en && ir_en_n) begin
        bus_oe  = 1'b1;
        bus_out = DATA_W'(pc_q);
      end else if (!pc_en && !ir_en_n) begin
        bus_oe  = 1'b1;
        bus_out = DATA_W'(ir_q[OP_W-1:0]);
      end
    end
  end

  assign opcode       = ir_q[DATA_W-1 -: OP_W];
  assign mar_addr     = mar_q;
  assign pc_value     = pc_q;
  assign pc_wrapped   = wrapped_q;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap_pc_ir_datapath.sv
// Directed bench for sap_pc_ir_datapath: expected state is queued per step and popped
// against the DUT outputs after each clock edge or strobe change.
`timescale 1ns/1ps
module tb_sap_pc_ir_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt, pc_inc, pc_en, pc_load, mar_load_n, ir_load_n, ir_en_n;
  logic [7:0] ext_bus;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe;
  logic [3:0] opcode, mar_addr, pc_value;
  logic       pc_wrapped, bus_conflict;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Resolved bus: this block's drive wins, otherwise whatever the rest of the system puts there.
  assign bus_in = bus_oe ? bus_out : ext_bus;

  sap_pc_ir_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .pc_inc(pc_inc), .pc_en(pc_en), .pc_load(pc_load),
    .mar_load_n(mar_load_n), .ir_load_n(ir_load_n), .ir_en_n(ir_en_n),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .opcode(opcode), .mar_addr(mar_addr), .pc_value(pc_value),
    .pc_wrapped(pc_wrapped), .bus_conflict(bus_conflict)
  );

  task automatic push(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_state(input logic [3:0] pc, input logic [3:0] mar, input logic [3:0] op,
                           input logic wr, input logic cf, input logic oe, input logic [7:0] bo);
    push("pc_value", 16'(pc));
    push("mar_addr", 16'(mar));
    push("opcode", 16'(op));
    push("pc_wrapped", 16'(wr));
    push("bus_conflict", 16'(cf));
    push("bus_oe", 16'(oe));
    push("bus_out", 16'(bo));
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fails++;
      $error("FAIL scoreboard_empty: observed %0h, required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fails++;
        $error("FAIL %s: observed %0h, expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_state();
    chk(16'(pc_value));
    chk(16'(mar_addr));
    chk(16'(opcode));
    chk(16'(pc_wrapped));
    chk(16'(bus_conflict));
    chk(16'(bus_oe));
    chk(16'(bus_out));
  endtask

  task automatic idle_strobes();
    halt       = 1'b0;
    pc_inc     = 1'b0;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    mar_load_n = 1'b1;
    ir_load_n  = 1'b1;
    ir_en_n    = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ext_bus = 8'h00;
    idle_strobes();

    // Reset values, held and after release
    repeat (2) @(posedge clk);
    #1 exp_state(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00); check_state();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 exp_state(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00); check_state();

    // Sixteen increments: 1..F then 0 with wrap flag on the last edge
    @(negedge clk) pc_inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_state(4'(i + 1), 4'h0, 4'h0, (i == 15), 1'b0, 1'b0, 8'h00);
      @(posedge clk);
      #1 check_state();
    end

    // Load has priority over increment; wrap flag stays set
    @(negedge clk) begin pc_load = 1'b1; ext_bus = 8'h09; end
    exp_state(4'h9, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    @(negedge clk) begin pc_inc = 1'b0; ext_bus = 8'h03; end
    exp_state(4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    // T0: PC drives bus, MAR captures it at the same edge
    @(negedge clk) begin pc_load = 1'b0; pc_en = 1'b1; mar_load_n = 1'b0; ext_bus = 8'hEE; end
    #1 exp_state(4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 8'h03); check_state();
    exp_state(4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'h03);
    @(posedge clk); #1 check_state();

    // T1: increment
    @(negedge clk) begin pc_en = 1'b0; mar_load_n = 1'b1; pc_inc = 1'b1; end
    exp_state(4'h4, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    // T2: IR load from memory data
    @(negedge clk) begin pc_inc = 1'b0; ir_load_n = 1'b0; ext_bus = 8'h2A; end
    exp_state(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    @(negedge clk) ext_bus = 8'h4C;
    exp_state(4'h4, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    // JMP path: IR operand onto bus, PC loads it
    @(negedge clk) begin ir_load_n = 1'b1; ir_en_n = 1'b0; pc_load = 1'b1; ext_bus = 8'h77; end
    #1 exp_state(4'h4, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1, 8'h0C); check_state();
    exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b0, 1'b1, 8'h0C);
    @(posedge clk); #1 check_state();

    // Bus conflict: released at once, flag after the edge, sticky afterwards
    @(negedge clk) begin pc_load = 1'b0; pc_en = 1'b1; end
    #1 exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 8'h00); check_state();
    exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();
    @(negedge clk) begin pc_en = 1'b0; ir_en_n = 1'b1; end
    repeat (2) @(posedge clk);
    #1 exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00); check_state();

    // Halt freezes everything and releases the bus
    @(negedge clk) begin
      halt = 1'b1; pc_inc = 1'b1; ir_load_n = 1'b0; mar_load_n = 1'b0; pc_en = 1'b1;
      ext_bus = 8'hFF;
    end
    #1 exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00); check_state();
    exp_state(4'hC, 4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();

    // Mid-cycle asynchronous reset
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 exp_state(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00); check_state();
    idle_strobes();
    @(negedge clk) rst_n = 1'b1;

    // A load to all-ones and then load+inc never sets the wrap flag
    @(negedge clk) begin pc_load = 1'b1; ext_bus = 8'h0F; end
    exp_state(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();
    @(negedge clk) begin pc_inc = 1'b1; ext_bus = 8'h09; end
    exp_state(4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 check_state();
    @(negedge clk) idle_strobes();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
